nubus_slave_ctrl: RTL and testbench

NUBUS_SLAVE_CTRL -- requirements
Module: nubus_slave_ctrl

---
 rtl/nubus_slave_ctrl_if.sv | 39 +++
 rtl/nubus_slave_ctrl.sv | 148 ++++++++++++++
 tb/tb_nubus_slave_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/nubus_slave_ctrl_if.sv
// NuBus slave signal bundle: bus-side lines (active-low, as sampled/driven)
// plus the simple request/ready memory port behind the slave.
interface nubus_slave_ctrl_if;
    logic [3:0]  nub_idn;
    logic [31:0] nub_adn_i;
    logic        nub_tm0n_i;
    logic        nub_tm1n_i;
    logic        nub_startn;
    logic        nub_ackn_i;
    logic [31:0] nub_adn_o;
    logic        nub_adn_oe;
    logic [1:0]  nub_tmn_o;
    logic        nub_ackn_o;
    logic        nub_ack_oe;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_myslot;
    logic        mem_super;
    logic        mem_error;
    logic        mem_tryagain;

    modport slave (
        input  nub_idn, nub_adn_i, nub_tm0n_i, nub_tm1n_i, nub_startn, nub_ackn_i,
        input  mem_ready, mem_rdata, mem_error, mem_tryagain,
        output nub_adn_o, nub_adn_oe, nub_tmn_o, nub_ackn_o, nub_ack_oe,
        output mem_valid, mem_write, mem_addr, mem_wdata, mem_myslot, mem_super
    );

    modport master (
        output nub_idn, nub_adn_i, nub_tm0n_i, nub_tm1n_i, nub_startn, nub_ackn_i,
        output mem_ready, mem_rdata, mem_error, mem_tryagain,
        input  nub_adn_o, nub_adn_oe, nub_tmn_o, nub_ackn_o, nub_ack_oe,
        input  mem_valid, mem_write, mem_addr, mem_wdata, mem_myslot, mem_super
    );
endinterface

// File: rtl/nubus_slave_ctrl.sv
// NuBus slave controller: decodes slot/superslot starts, runs one memory
// request per bus cycle with a watchdog, and answers with a single ACK cycle.
module nubus_slave_ctrl #(
    parameter int WDT_W        = 3,
    parameter bit SUPERSLOT_EN = 1'b1
) (
    input  logic               nub_clkn,
    input  logic               nub_resetn,
    nubus_slave_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WDATA, MEM, ACK} state_t;

    localparam logic [WDT_W-1:0] WDT_MAX = '1;

    state_t             state, state_nx;
    logic [31:0]        addr_t;
    logic [3:0]         slot_id;
    logic               start, slot_hit, super_hit, hit;
    logic               tm1, tm0;
    logic [3:0]         strobe;
    logic               unsup;
    logic               exit_mem;
    logic [1:0]         status_nx;
    logic [WDT_W-1:0]   wdt;
    logic               is_read, unsup_q;
    logic [1:0]         status_q;
    logic [31:0]        rdata_q;
    logic [31:0]        addr_q, wdata_q;
    logic [3:0]         write_q;
    logic               myslot_q, super_q;

    assign addr_t    = ~bus.nub_adn_i;
    assign slot_id   = ~bus.nub_idn;
    assign tm1       = ~bus.nub_tm1n_i;
    assign tm0       = ~bus.nub_tm0n_i;
    assign start     = ~bus.nub_startn & bus.nub_ackn_i;
    assign slot_hit  = (addr_t[31:24] == {4'hF, slot_id});
    assign super_hit = SUPERSLOT_EN && (addr_t[31:28] == slot_id)
                       && (slot_id != 4'h0) && (slot_id != 4'hF);
    assign hit       = slot_hit | super_hit;
    assign exit_mem  = bus.mem_error | bus.mem_tryagain | bus.mem_ready | (wdt == WDT_MAX);

    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_write  = write_q;
    assign bus.mem_myslot = myslot_q;
    assign bus.mem_super  = super_q;

    // Byte-lane strobes from transfer mode; the 10 half-word alignment is unsupported.
    always_comb begin
        strobe = 4'b0000;
        unsup  = 1'b0;
        if (!tm1) begin
            if (tm0) begin
                strobe = 4'b0001 << addr_t[1:0];
            end else begin
                case (addr_t[1:0])
                    2'b00:   strobe = 4'b1111;
                    2'b01:   strobe = 4'b0011;
                    2'b11:   strobe = 4'b1100;
                    default: unsup  = 1'b1;
                endcase
            end
        end
    end

    // Completion status, highest-priority qualifier wins; watchdog is the fallback.
    always_comb begin
        status_nx = 2'b10;
        if (bus.mem_error)         status_nx = 2'b01;
        else if (bus.mem_tryagain) status_nx = 2'b11;
        else if (bus.mem_ready)    status_nx = 2'b00;
    end

    // State register.
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) state <= IDLE;
        else             state <= state_nx;
    end

    // Next-state and bus/memory strobes decoded from the current state.
    always_comb begin
        state_nx       = state;
        bus.mem_valid  = 1'b0;
        bus.nub_ack_oe = 1'b0;
        bus.nub_ackn_o = 1'b1;
        bus.nub_tmn_o  = 2'b11;
        bus.nub_adn_oe = 1'b0;
        bus.nub_adn_o  = '1;
        case (state)
            IDLE:  if (start && hit) state_nx = tm1 ? MEM : WDATA;
            WDATA: state_nx = unsup_q ? ACK : MEM;
            MEM: begin
                bus.mem_valid = 1'b1;
                if (exit_mem) state_nx = ACK;
            end
            ACK: begin
                state_nx       = IDLE;
                bus.nub_ack_oe = 1'b1;
                bus.nub_ackn_o = 1'b0;
                bus.nub_tmn_o  = ~status_q;
                if (is_read && status_q == 2'b00) begin
                    bus.nub_adn_oe = 1'b1;
                    bus.nub_adn_o  = ~rdata_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Transaction context: latched at the start edge, write data in WDATA, result at MEM exit.
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= '0;
            myslot_q <= 1'b0;
            super_q  <= 1'b0;
            is_read  <= 1'b0;
            unsup_q  <= 1'b0;
            status_q <= 2'b00;
            rdata_q  <= '0;
            wdt      <= '0;
        end else begin
            if (state == IDLE && start && hit) begin
                addr_q   <= {addr_t[31:2], 2'b00};
                write_q  <= strobe;
                myslot_q <= slot_hit;
                super_q  <= super_hit & ~slot_hit;
                is_read  <= tm1;
                unsup_q  <= unsup;
            end
            if (state == WDATA) begin
                wdata_q <= ~bus.nub_adn_i;
                if (unsup_q) status_q <= 2'b01;
            end
            if (state == MEM) begin
                if (wdt != WDT_MAX) wdt <= wdt + 1'b1;
                if (exit_mem) begin
                    status_q <= status_nx;
                    rdata_q  <= bus.mem_rdata;
                end
            end else begin
                wdt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// Directed bench for nubus_slave_ctrl: bus starts and memory responses are
// driven on the falling edge, outputs are checked on the falling edge.
module tb_nubus_slave_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cnt;
    logic seen;

    nubus_slave_ctrl_if bus();

    nubus_slave_ctrl #(.WDT_W(3), .SUPERSLOT_EN(1'b1)) dut (
        .nub_clkn   (clk),
        .nub_resetn (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_start(input logic [31:0] a, input logic t1, input logic t0);
        bus.nub_startn = 1'b0;
        bus.nub_adn_i  = ~a;
        bus.nub_tm1n_i = ~t1;
        bus.nub_tm0n_i = ~t0;
    endtask

    task automatic drive_data(input logic [31:0] d);
        bus.nub_startn = 1'b1;
        bus.nub_adn_i  = ~d;
        bus.nub_tm1n_i = 1'b1;
        bus.nub_tm0n_i = 1'b1;
    endtask

    task automatic bus_idle();
        drive_data(32'h0000_0000);
    endtask

    initial begin
        bus.nub_idn      = 4'h6;
        bus.nub_ackn_i   = 1'b1;
        bus.mem_ready    = 1'b0;
        bus.mem_error    = 1'b0;
        bus.mem_tryagain = 1'b0;
        bus.mem_rdata    = 32'h0;
        bus_idle();

        // reset state
        #12;
        chk("rst_valid",  32'(bus.mem_valid),  32'h0);
        chk("rst_ack_oe", 32'(bus.nub_ack_oe), 32'h0);
        chk("rst_ackn",   32'(bus.nub_ackn_o), 32'h1);
        chk("rst_tmn",    32'(bus.nub_tmn_o),  32'h3);
        chk("rst_adn_o",  bus.nub_adn_o,       32'hFFFF_FFFF);
        chk("rst_adn_oe", 32'(bus.nub_adn_oe), 32'h0);
        chk("rst_addr",   bus.mem_addr,        32'h0);
        chk("rst_write",  32'(bus.mem_write),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // write word to own slot
        drive_start(32'hF900_0000, 1'b0, 1'b0);
        tick();
        drive_data(32'h8765_4321);
        chk("wr_wdata_novalid", 32'(bus.mem_valid), 32'h0);
        tick();
        bus_idle();
        chk("wr_valid",  32'(bus.mem_valid),  32'h1);
        chk("wr_write",  32'(bus.mem_write),  32'hF);
        chk("wr_wdata",  bus.mem_wdata,       32'h8765_4321);
        chk("wr_addr",   bus.mem_addr,        32'hF900_0000);
        chk("wr_myslot", 32'(bus.mem_myslot), 32'h1);
        chk("wr_super",  32'(bus.mem_super),  32'h0);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("wr_ack_oe", 32'(bus.nub_ack_oe), 32'h1);
        chk("wr_ackn",   32'(bus.nub_ackn_o), 32'h0);
        chk("wr_tmn",    32'(bus.nub_tmn_o),  32'h3);
        chk("wr_adn_oe", 32'(bus.nub_adn_oe), 32'h0);
        chk("wr_ack_novalid", 32'(bus.mem_valid), 32'h0);
        tick();
        chk("wr_ack_once", 32'(bus.nub_ack_oe), 32'h0);

        // byte-lane read; a start presented during ACK must be ignored
        drive_start(32'hF900_0018, 1'b1, 1'b1);
        tick();
        bus_idle();
        chk("rd_valid", 32'(bus.mem_valid), 32'h1);
        chk("rd_write", 32'(bus.mem_write), 32'h0);
        chk("rd_addr",  bus.mem_addr,       32'hF900_0018);
        bus.mem_rdata = 32'h1234_5678;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("rd_ack_oe", 32'(bus.nub_ack_oe), 32'h1);
        chk("rd_adn_oe", 32'(bus.nub_adn_oe), 32'h1);
        chk("rd_adn_o",  bus.nub_adn_o,       32'hEDCB_A987);
        chk("rd_tmn",    32'(bus.nub_tmn_o),  32'h3);
        drive_start(32'hF900_0000, 1'b1, 1'b0);
        tick();
        bus_idle();
        chk("ack_start_ignored_valid", 32'(bus.mem_valid),  32'h0);
        chk("ack_start_ignored_ack",   32'(bus.nub_ack_oe), 32'h0);

        // superslot write byte, started in the cycle after ACK
        drive_start(32'h9000_1011, 1'b0, 1'b1);
        tick();
        drive_data(32'h0000_00AA);
        tick();
        bus_idle();
        chk("ss_valid",  32'(bus.mem_valid),  32'h1);
        chk("ss_write",  32'(bus.mem_write),  32'h2);
        chk("ss_super",  32'(bus.mem_super),  32'h1);
        chk("ss_myslot", 32'(bus.mem_myslot), 32'h0);
        chk("ss_addr",   bus.mem_addr,        32'h9000_1010);
        chk("ss_wdata",  bus.mem_wdata,       32'h0000_00AA);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("ss_tmn", 32'(bus.nub_tmn_o), 32'h3);
        tick();

        // start to another slot: no response
        drive_start(32'hF600_2000, 1'b1, 1'b1);
        tick();
        bus_idle();
        chk("miss_valid0", 32'(bus.mem_valid),  32'h0);
        chk("miss_ack0",   32'(bus.nub_ack_oe), 32'h0);
        tick();
        chk("miss_valid1", 32'(bus.mem_valid),  32'h0);
        chk("miss_ack1",   32'(bus.nub_ack_oe), 32'h0);

        // upper half-word write with error and ready together
        drive_start(32'hF900_0003, 1'b0, 1'b0);
        tick();
        drive_data(32'h1111_2222);
        tick();
        bus_idle();
        chk("hw_write", 32'(bus.mem_write), 32'hC);
        chk("hw_addr",  bus.mem_addr,       32'hF900_0000);
        bus.mem_error = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_error = 1'b0;
        bus.mem_ready = 1'b0;
        chk("err_ack_oe", 32'(bus.nub_ack_oe), 32'h1);
        chk("err_tmn",    32'(bus.nub_tmn_o),  32'h2);
        tick();

        // unsupported mode: straight to ACK with error, no memory access
        drive_start(32'hF900_0002, 1'b0, 1'b0);
        tick();
        drive_data(32'h0);
        chk("uns_wdata_valid", 32'(bus.mem_valid), 32'h0);
        tick();
        bus_idle();
        chk("uns_valid",  32'(bus.mem_valid),  32'h0);
        chk("uns_ack_oe", 32'(bus.nub_ack_oe), 32'h1);
        chk("uns_tmn",    32'(bus.nub_tmn_o),  32'h2);
        tick();
        chk("uns_ack_once", 32'(bus.nub_ack_oe), 32'h0);

        // read answered with try-again: no data driven
        drive_start(32'hF900_0020, 1'b1, 1'b0);
        tick();
        bus_idle();
        bus.mem_rdata    = 32'hAAAA_5555;
        bus.mem_tryagain = 1'b1;
        tick();
        bus.mem_tryagain = 1'b0;
        chk("try_ack_oe", 32'(bus.nub_ack_oe), 32'h1);
        chk("try_tmn",    32'(bus.nub_tmn_o),  32'h0);
        chk("try_adn_oe", 32'(bus.nub_adn_oe), 32'h0);
        tick();

        // watchdog timeout
        drive_start(32'hF900_0100, 1'b1, 1'b0);
        tick();
        bus_idle();
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.nub_ack_oe) begin
                seen = 1'b1;
                break;
            end
            if (bus.mem_valid) cnt++;
            tick();
        end
        chk("wdt_ack_seen", 32'(seen),           32'h1);
        chk("wdt_cycles",   cnt,                 32'd8);
        chk("wdt_tmn",      32'(bus.nub_tmn_o),  32'h1);
        chk("wdt_adn_oe",   32'(bus.nub_adn_oe), 32'h0);
        tick();

        // reset pulse in the middle of a memory cycle
        drive_start(32'hF900_0040, 1'b1, 1'b0);
        tick();
        bus_idle();
        chk("mr_valid_pre", 32'(bus.mem_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid",  32'(bus.mem_valid),  32'h0);
        chk("mr_ack_oe", 32'(bus.nub_ack_oe), 32'h0);
        chk("mr_adn_oe", 32'(bus.nub_adn_oe), 32'h0);
        chk("mr_addr",   bus.mem_addr,        32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(32'hF900_0044, 1'b1, 1'b0);
        tick();
        bus_idle();
        chk("pr_valid", 32'(bus.mem_valid), 32'h1);
        chk("pr_addr",  bus.mem_addr,       32'hF900_0044);
        bus.mem_rdata = 32'hCAFE_F00D;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk("pr_adn_oe", 32'(bus.nub_adn_oe), 32'h1);
        chk("pr_adn_o",  bus.nub_adn_o,       32'h3501_0FF2);
        chk("pr_tmn",    32'(bus.nub_tmn_o),  32'h3);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
